// File: rtl/serial_rx_if.sv
// Bundle between the serial receive front end and its consumer: synchronized
// line, read strobe, received word and status flags.
interface serial_rx_if #(
   parameter int NUM_DATA_BITS = 8
);
   logic                     serial_in;
   logic                     data_read;
   logic [NUM_DATA_BITS-1:0] rx_data;
   logic                     data_ready;
   logic                     framing_error;
   logic                     overrun_error;

   modport master (
      output serial_in,
      output data_read,
      input  rx_data,
      input  data_ready,
      input  framing_error,
      input  overrun_error
   );

   modport slave (
      input  serial_in,
      input  data_read,
      output rx_data,
      output data_ready,
      output framing_error,
      output overrun_error
   );
endinterface

// File: rtl/serial_rx_ctrl.sv
// Serial receiver: start-edge detect, mid-bit sampling of an LSB-first frame,
// stop-bit check and a ready/read handshake with framing/overrun flags.
module serial_rx_ctrl #(
   parameter int NUM_DATA_BITS = 8,
   parameter int CLKS_PER_BIT  = 10
) (
   input  logic        clk,
   input  logic        n_rst,
   serial_rx_if.slave  bus
);
   localparam int TMR_W = $clog2(CLKS_PER_BIT);
   localparam int CNT_W = $clog2(NUM_DATA_BITS + 1);
   localparam logic [TMR_W-1:0] HALF_M1  = TMR_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TMR_W-1:0] FULL_M1  = TMR_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NUM_DATA_BITS - 1);

   typedef enum logic [1:0] {IDLE, START_CHK, RECV, STOP_CHK} state_t;

   state_t                   state, state_nxt;
   logic [TMR_W-1:0]         timer;
   logic [CNT_W-1:0]         bit_cnt;
   logic                     serial_p0;
   logic [NUM_DATA_BITS-1:0] shift_reg;

   logic start_edge, sample_pt, start_ok, shift_en, load, frame_bad, rd_ack;

   assign start_edge = serial_p0 && !bus.serial_in;
   assign rd_ack     = bus.data_read && bus.data_ready;

   // State register
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (start_edge) state_nxt = START_CHK;
         START_CHK: if (timer == HALF_M1) state_nxt = bus.serial_in ? IDLE : RECV;
         RECV:      if (timer == FULL_M1 && bit_cnt == LAST_BIT) state_nxt = STOP_CHK;
         STOP_CHK:  if (timer == FULL_M1) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   // Per-state strobes; the first sample is half a bit in, the rest a full bit apart
   always_comb begin
      sample_pt = 1'b0;
      start_ok  = 1'b0;
      shift_en  = 1'b0;
      load      = 1'b0;
      frame_bad = 1'b0;
      case (state)
         START_CHK: begin
            sample_pt = (timer == HALF_M1);
            start_ok  = sample_pt && !bus.serial_in;
         end
         RECV: begin
            sample_pt = (timer == FULL_M1);
            shift_en  = sample_pt;
         end
         STOP_CHK: begin
            sample_pt = (timer == FULL_M1);
            load      = sample_pt && bus.serial_in;
            frame_bad = sample_pt && !bus.serial_in;
         end
         default: ;
      endcase
   end

   // Edge register and counters
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         serial_p0 <= 1'b1;
         timer     <= '0;
         bit_cnt   <= '0;
      end else begin
         serial_p0 <= bus.serial_in;
         if (state == IDLE || sample_pt) timer <= '0;
         else                            timer <= timer + TMR_W'(1);
         if (state == IDLE)  bit_cnt <= '0;
         else if (shift_en)  bit_cnt <= bit_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (shift_en)
         shift_reg <= (shift_reg >> 1) | (NUM_DATA_BITS'(bus.serial_in) << (NUM_DATA_BITS - 1));
   end

   // Output word and status flags; a read coincident with a load acknowledges the old word
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         bus.rx_data       <= '0;
         bus.data_ready    <= 1'b0;
         bus.framing_error <= 1'b0;
         bus.overrun_error <= 1'b0;
      end else begin
         if (load) begin
            bus.rx_data    <= shift_reg;
            bus.data_ready <= 1'b1;
         end else if (rd_ack) begin
            bus.data_ready <= 1'b0;
         end

         if (load && bus.data_ready && !bus.data_read) bus.overrun_error <= 1'b1;
         else if (rd_ack)                              bus.overrun_error <= 1'b0;

         if (start_ok)       bus.framing_error <= 1'b0;
         else if (frame_bad) bus.framing_error <= 1'b1;
      end
   end
endmodule

// File: tb/tb_serial_rx_ctrl.sv
// Bench for serial_rx_ctrl: directed frames plus randomized frames, reads and
// glitches, compared against a frame-level model of the receiver.
module tb_serial_rx_ctrl;
   localparam int N = 8;
   localparam int C = 10;
   localparam int H = C / 2;

   logic clk   = 1'b0;
   logic n_rst = 1'b0;
   always #5 clk = ~clk;

   serial_rx_if #(.NUM_DATA_BITS(N)) bus ();

   serial_rx_ctrl #(.NUM_DATA_BITS(N), .CLKS_PER_BIT(C)) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus.slave)
   );

   int n_cmp = 0;
   int n_mis = 0;

   logic [N-1:0] m_data;
   logic         m_ready, m_ferr, m_ovr;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, "_data"}, 32'(bus.rx_data),       32'(m_data));
      chk({tag, "_rdy"},  32'(bus.data_ready),    32'(m_ready));
      chk({tag, "_ferr"}, 32'(bus.framing_error), 32'(m_ferr));
      chk({tag, "_ovr"},  32'(bus.overrun_error), 32'(m_ovr));
   endtask

   task automatic m_reset();
      m_data  = '0;
      m_ready = 1'b0;
      m_ferr  = 1'b0;
      m_ovr   = 1'b0;
   endtask

   task automatic m_read();
      if (m_ready) begin
         m_ready = 1'b0;
         m_ovr   = 1'b0;
      end
   endtask

   // Effect of one complete frame whose start bit is valid
   task automatic m_frame(input logic [N-1:0] d, input logic stop, input logic rd);
      m_ferr = 1'b0;
      if (stop) begin
         if (m_ready) m_ovr = !rd;
         m_data  = d;
         m_ready = 1'b1;
      end else begin
         m_ferr = 1'b1;
         if (rd) m_read();
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive_bit(input logic v);
      bus.serial_in = v;
      repeat (C) @(negedge clk);
   endtask

   task automatic send_frame(input logic [N-1:0] d, input logic stop, input logic rd,
                             input bit lat, input int gap, input string tag);
      drive_bit(1'b0);
      for (int i = 0; i < N; i++) drive_bit(d[i]);
      bus.serial_in = stop;
      for (int j = 0; j < C; j++) begin
         bus.data_read = rd && (j == H);
         @(negedge clk);
         if (j == H - 1) begin
            if (lat) chk({tag, "_lat_pre"}, 32'(bus.data_ready), 32'(m_ready));
            m_frame(d, stop, rd);
         end
         if (j == H && lat) chk({tag, "_lat_post"}, 32'(bus.data_ready), 32'(m_ready));
      end
      bus.data_read = 1'b0;
      bus.serial_in = 1'b1;
      idle(gap);
      check_all(tag);
   endtask

   task automatic pulse_read(input string tag);
      bus.data_read = 1'b1;
      @(negedge clk);
      bus.data_read = 1'b0;
      m_read();
      idle(1);
      check_all(tag);
   endtask

   task automatic glitch(input int g, input string tag);
      bus.serial_in = 1'b0;
      repeat (g) @(negedge clk);
      bus.serial_in = 1'b1;
      idle(H + 4);
      check_all(tag);
   endtask

   initial begin
      logic [N-1:0] d;
      logic [N-1:0] part;
      logic         stop, rd;
      int           op;

      bus.serial_in = 1'b1;
      bus.data_read = 1'b0;
      m_reset();
      idle(3);
      check_all("rst");
      n_rst = 1'b1;
      idle(50);
      check_all("idle");

      send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 2, "a5");
      pulse_read("rd_a5");
      glitch(3, "glitch3");

      send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 2, "stop0");
      send_frame(8'h11, 1'b1, 1'b0, 1'b0, 2, "x11");
      pulse_read("rd_11");

      send_frame(8'h01, 1'b1, 1'b0, 1'b0, 2, "ov1");
      send_frame(8'h02, 1'b1, 1'b0, 1'b0, 2, "ov2");
      pulse_read("rd_ov");
      send_frame(8'h01, 1'b1, 1'b0, 1'b0, 2, "co1");
      send_frame(8'h02, 1'b1, 1'b1, 1'b0, 2, "co2");

      // Reset during bit 4 of a frame
      part = 8'h5A;
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(part[i]);
      bus.serial_in = part[4];
      idle(3);
      n_rst = 1'b0;
      #1;
      chk("mid_rst_data", 32'(bus.rx_data),       32'h0);
      chk("mid_rst_rdy",  32'(bus.data_ready),    32'h0);
      chk("mid_rst_ferr", 32'(bus.framing_error), 32'h0);
      chk("mid_rst_ovr",  32'(bus.overrun_error), 32'h0);
      m_reset();
      bus.serial_in = 1'b1;
      idle(3);
      n_rst = 1'b1;
      idle(5);
      check_all("post_rst");
      send_frame(8'hFF, 1'b1, 1'b0, 1'b1, 2, "xff");

      for (int t = 0; t < 40; t++) begin
         op = $urandom_range(0, 9);
         if (op <= 5) begin
            d    = N'($urandom);
            stop = ($urandom_range(0, 4) != 0);
            rd   = ($urandom_range(0, 3) == 0);
            send_frame(d, stop, rd, 1'b0, $urandom_range(1, 6), "rnd_frame");
         end else if (op <= 7) begin
            pulse_read("rnd_read");
         end else begin
            glitch($urandom_range(1, H - 1), "rnd_glitch");
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
